// File: rtl/mem_arbiter.sv
// Round-robin arbiter giving two requesters (CPU, loader) shared access to a
// single-port synchronous RAM; one transaction in flight, all outputs registered.
module mem_arbiter #(
    parameter int AW = 9,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req0,
    input  logic          req1,
    input  logic          we0,
    input  logic          we1,
    input  logic [AW-1:0] addr0,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata0,
    input  logic [DW-1:0] wdata1,
    output logic          gnt0,
    output logic          gnt1,
    output logic          rvalid0,
    output logic          rvalid1,
    output logic [DW-1:0] rdata,
    output logic          busy,
    output logic [AW-1:0] ram_raddr,
    output logic [AW-1:0] ram_waddr,
    output logic [DW-1:0] ram_wdata,
    output logic          ram_we,
    input  logic [DW-1:0] ram_rdata
);

    // IDLE: arbitrate | ACCESS: RAM cycle | RWAIT: RAM read latency | RDONE: rvalid
    typedef enum logic [1:0] {IDLE, ACCESS, RWAIT, RDONE} state_t;

    state_t        r_state;
    logic          r_last;
    logic          r_port;
    logic          r_we;

    logic          w_any;
    logic          w_sel;
    logic          w_we;
    logic [AW-1:0] w_addr;
    logic [DW-1:0] w_wdata;

    always_comb begin
        w_any   = req0 | req1;
        w_sel   = (req0 & req1) ? ~r_last : req1;
        w_we    = w_sel ? we1 : we0;
        w_addr  = w_sel ? addr1 : addr0;
        w_wdata = w_sel ? wdata1 : wdata0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_last    <= 1'b1;
            r_port    <= 1'b0;
            r_we      <= 1'b0;
            gnt0      <= 1'b0;
            gnt1      <= 1'b0;
            rvalid0   <= 1'b0;
            rvalid1   <= 1'b0;
            busy      <= 1'b0;
            ram_we    <= 1'b0;
            ram_raddr <= '0;
            ram_waddr <= '0;
            ram_wdata <= '0;
            rdata     <= '0;
        end else begin
            gnt0    <= 1'b0;
            gnt1    <= 1'b0;
            rvalid0 <= 1'b0;
            rvalid1 <= 1'b0;
            ram_we  <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_state <= ACCESS;
                        busy    <= 1'b1;
                        r_port  <= w_sel;
                        r_last  <= w_sel;
                        r_we    <= w_we;
                        gnt0    <= ~w_sel;
                        gnt1    <= w_sel;
                        // RAM-side registers double as the operand latch
                        if (w_we) begin
                            ram_we    <= 1'b1;
                            ram_waddr <= w_addr;
                            ram_wdata <= w_wdata;
                        end else begin
                            ram_raddr <= w_addr;
                        end
                    end
                end
                ACCESS: begin
                    if (r_we) begin
                        r_state <= IDLE;
                        busy    <= 1'b0;
                    end else begin
                        r_state <= RWAIT;
                    end
                end
                RWAIT: begin
                    r_state <= RDONE;
                    rdata   <= ram_rdata;
                    rvalid0 <= ~r_port;
                    rvalid1 <= r_port;
                end
                RDONE: begin
                    r_state <= IDLE;
                    busy    <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus random traffic, checked every
// cycle against a transaction-level timing/memory model.
module tb_mem_arbiter;

    localparam int AW   = 9;
    localparam int DW   = 8;
    localparam int MAXC = 4000;

    logic          clk = 1'b0;
    logic          rst;
    logic          req0, req1, we0, we1;
    logic [AW-1:0] addr0, addr1;
    logic [DW-1:0] wdata0, wdata1;
    logic          gnt0, gnt1, rvalid0, rvalid1, busy, ram_we;
    logic [DW-1:0] rdata, ram_wdata, ram_rdata;
    logic [AW-1:0] ram_raddr, ram_waddr;

    always #5 clk = ~clk;

    mem_arbiter #(.AW(AW), .DW(DW)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
        .rdata(rdata), .busy(busy),
        .ram_raddr(ram_raddr), .ram_waddr(ram_waddr), .ram_wdata(ram_wdata),
        .ram_we(ram_we), .ram_rdata(ram_rdata)
    );

    // Synchronous RAM: data appears one cycle after the address is sampled
    bit [DW-1:0] tmem [1<<AW];
    always @(posedge clk) begin
        if (ram_we) tmem[ram_waddr] <= ram_wdata;
        ram_rdata <= tmem[ram_raddr];
    end

    typedef struct packed {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } cmd_t;

    cmd_t q0[$], q1[$];
    bit   rst_next;
    int   cyc = 0;
    int   n_chk = 0, n_fail = 0;

    // Expected per-cycle pulses and scheduled updates of held outputs
    bit            e_gnt0[MAXC], e_gnt1[MAXC], e_rv0[MAXC], e_rv1[MAXC], e_busy[MAXC], e_we[MAXC];
    bit            u_ra_v[MAXC], u_w_v[MAXC], u_rd_v[MAXC];
    logic [AW-1:0] u_raddr[MAXC], u_waddr[MAXC];
    logic [DW-1:0] u_wdata[MAXC], u_rdata[MAXC];
    logic [AW-1:0] m_raddr, m_waddr;
    logic [DW-1:0] m_wdata, m_rdata;
    bit   [DW-1:0] refmem[1<<AW];
    int            m_free = 0;
    bit            m_last = 1'b1;

    int og_cyc[$], og_port[$], or_cyc[$], or_port[$], or_data[$];

    task automatic check_eq(string tag, logic [31:0] got, logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @cycle %0d: got 0x%0h expected 0x%0h", tag, cyc, got, exp);
        end
    endtask

    task automatic predict(int e);
        bit            win, w;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        if (e + 4 >= MAXC) return;
        if (rst) begin
            for (int i = e; i < MAXC; i++) begin
                e_gnt0[i] = 0; e_gnt1[i] = 0; e_rv0[i] = 0; e_rv1[i] = 0;
                e_busy[i] = 0; e_we[i] = 0; u_ra_v[i] = 0; u_w_v[i] = 0; u_rd_v[i] = 0;
            end
            u_ra_v[e] = 1; u_raddr[e] = '0;
            u_w_v[e]  = 1; u_waddr[e] = '0; u_wdata[e] = '0;
            u_rd_v[e] = 1; u_rdata[e] = '0;
            m_last = 1'b1;
            m_free = e + 1;
        end else if (e >= m_free && (req0 || req1)) begin
            win = (req0 && req1) ? !m_last : req1;
            m_last = win;
            w = win ? we1 : we0;
            a = win ? addr1 : addr0;
            d = win ? wdata1 : wdata0;
            if (win) e_gnt1[e] = 1; else e_gnt0[e] = 1;
            e_busy[e] = 1;
            if (w) begin
                e_we[e] = 1;
                u_w_v[e] = 1; u_waddr[e] = a; u_wdata[e] = d;
                refmem[a] = d;
                m_free = e + 2;
            end else begin
                u_ra_v[e] = 1; u_raddr[e] = a;
                e_busy[e+1] = 1; e_busy[e+2] = 1;
                u_rd_v[e+2] = 1; u_rdata[e+2] = refmem[a];
                if (win) e_rv1[e+2] = 1; else e_rv0[e+2] = 1;
                m_free = e + 4;
            end
        end
    endtask

    task automatic check_cycle(int n);
        if (u_ra_v[n]) m_raddr = u_raddr[n];
        if (u_w_v[n]) begin m_waddr = u_waddr[n]; m_wdata = u_wdata[n]; end
        if (u_rd_v[n]) m_rdata = u_rdata[n];
        check_eq("gnt0", gnt0, e_gnt0[n]);
        check_eq("gnt1", gnt1, e_gnt1[n]);
        check_eq("rvalid0", rvalid0, e_rv0[n]);
        check_eq("rvalid1", rvalid1, e_rv1[n]);
        check_eq("busy", busy, e_busy[n]);
        check_eq("ram_we", ram_we, e_we[n]);
        check_eq("ram_raddr", ram_raddr, m_raddr);
        check_eq("ram_waddr", ram_waddr, m_waddr);
        check_eq("ram_wdata", ram_wdata, m_wdata);
        check_eq("rdata", rdata, m_rdata);
        if (gnt0 === 1'b1 || gnt1 === 1'b1) begin og_cyc.push_back(n); og_port.push_back(int'(gnt1)); end
        if (rvalid0 === 1'b1 || rvalid1 === 1'b1) begin
            or_cyc.push_back(n); or_port.push_back(int'(rvalid1)); or_data.push_back(int'(rdata));
        end
    endtask

    // Requesters: hold until granted, then drop or present the next queued command
    task automatic drive();
        cmd_t c;
        if (rst_next) begin
            q0.delete(); q1.delete();
            req0 = 1'b0; req1 = 1'b0;
        end else begin
            if (req0 && gnt0 === 1'b1) req0 = 1'b0;
            if (req1 && gnt1 === 1'b1) req1 = 1'b0;
            if (!req0 && q0.size() > 0) begin
                c = q0.pop_front(); req0 = 1'b1; we0 = c.we; addr0 = c.addr; wdata0 = c.data;
            end
            if (!req1 && q1.size() > 0) begin
                c = q1.pop_front(); req1 = 1'b1; we1 = c.we; addr1 = c.addr; wdata1 = c.data;
            end
        end
        rst = rst_next;
    endtask

    task automatic step();
        @(negedge clk);
        cyc++;
        check_cycle(cyc);
        drive();
        predict(cyc + 1);
    endtask

    task automatic drain(int budget);
        int k = 0;
        while (k < budget && (q0.size() + q1.size() != 0 || req0 || req1 || cyc + 1 < m_free)) begin
            step();
            k++;
        end
        check_eq("drain_pending", q0.size() + q1.size() + int'(req0) + int'(req1), 0);
    endtask

    task automatic clear_obs();
        og_cyc.delete(); og_port.delete(); or_cyc.delete(); or_port.delete(); or_data.delete();
    endtask

    function automatic cmd_t mk(bit w, int a, int d);
        cmd_t c;
        c.we = w; c.addr = AW'(a); c.data = DW'(d);
        return c;
    endfunction

    function automatic cmd_t rnd_cmd();
        int sel = $urandom_range(0, 3);
        int a   = (sel == 0) ? 0 : (sel == 1) ? (1 << AW) - 1 : $urandom_range(0, (1 << AW) - 1);
        return mk($urandom_range(0, 1) == 1, a, $urandom_range(0, 255));
    endfunction

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        req0 = 0; req1 = 0; we0 = 0; we1 = 0;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
        rst_next = 1'b1;
        drive();
        predict(1);
        repeat (3) step();
        rst_next = 1'b0;

        // single write
        clear_obs();
        q0.push_back(mk(1, 'h1A5, 'h3C));
        drain(20);
        check_eq("t_wr_ngnt", og_cyc.size(), 1);
        if (og_port.size() > 0) check_eq("t_wr_port", og_port[0], 0);

        // single read on port 1 after placing 0x7E at 0x010
        q1.push_back(mk(1, 'h010, 'h7E));
        drain(20);
        clear_obs();
        q1.push_back(mk(0, 'h010, 0));
        drain(20);
        check_eq("t_rd_nrv", or_cyc.size(), 1);
        if (or_cyc.size() > 0 && og_cyc.size() > 0) begin
            check_eq("t_rd_port", or_port[0], 1);
            check_eq("t_rd_lat", or_cyc[0] - og_cyc[0], 2);
            check_eq("t_rd_data", or_data[0], 'h7E);
        end

        // contention straight after reset
        rst_next = 1'b1; step(); rst_next = 1'b0;
        clear_obs();
        for (int i = 0; i < 2; i++) begin
            q0.push_back(mk(1, 'h20 + i, 'h10 + i));
            q1.push_back(mk(1, 'h40 + i, 'h50 + i));
        end
        drain(40);
        check_eq("t_cont_ngnt", og_cyc.size(), 4);
        for (int i = 0; i < og_cyc.size() && i < 4; i++) begin
            check_eq("t_cont_order", og_port[i], i % 2);
            if (i > 0) check_eq("t_cont_space", og_cyc[i] - og_cyc[i-1], 2);
        end

        // back-to-back reads on port 0
        for (int i = 0; i < 4; i++) q0.push_back(mk(1, i, 'hA0 + i));
        drain(40);
        clear_obs();
        for (int i = 0; i < 4; i++) q0.push_back(mk(0, i, 0));
        drain(60);
        check_eq("t_b2b_nrv", or_cyc.size(), 4);
        for (int i = 0; i < or_cyc.size() && i < 4; i++) begin
            check_eq("t_b2b_port", or_port[i], 0);
            check_eq("t_b2b_data", or_data[i], 'hA0 + i);
            if (i > 0) check_eq("t_b2b_space", or_cyc[i] - or_cyc[i-1], 4);
        end

        // reset during RWAIT
        clear_obs();
        q0.push_back(mk(0, 2, 0));
        for (int k = 0; k < 20 && og_cyc.size() == 0; k++) step();
        check_eq("t_abort_gnt", og_cyc.size(), 1);
        rst_next = 1'b1; step(); rst_next = 1'b0;
        step();
        check_eq("t_abort_busy", busy, 0);
        check_eq("t_abort_rdata", rdata, 0);
        drain(20);
        check_eq("t_abort_nrv", or_cyc.size(), 0);
        clear_obs();
        q1.push_back(mk(0, 3, 0));
        drain(20);
        check_eq("t_after_nrv", or_cyc.size(), 1);
        if (or_data.size() > 0) check_eq("t_after_data", or_data[0], 'hA3);

        // maximum address
        clear_obs();
        q0.push_back(mk(1, 'h1FF, 'hFF));
        q0.push_back(mk(0, 'h1FF, 0));
        drain(30);
        check_eq("t_max_nrv", or_cyc.size(), 1);
        if (or_data.size() > 0) check_eq("t_max_data", or_data[0], 'hFF);

        // random traffic with occasional resets
        for (int k = 0; k < 1200; k++) begin
            rst_next = ($urandom_range(0, 299) == 0);
            if (q0.size() < 2 && $urandom_range(0, 3) == 0) q0.push_back(rnd_cmd());
            if (q1.size() < 2 && $urandom_range(0, 3) == 0) q1.push_back(rnd_cmd());
            step();
        end
        rst_next = 1'b0;
        drain(200);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have parameter AW, default 9, meaning RAM address width in bits.
REQ-002 The block SHALL have parameter DW, default 8, meaning RAM data width in bits.
REQ-003 The block SHALL have port clk  input  1  system clock; all state changes on rising edge.
REQ-004 The block SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 The block SHALL have ports req0/req1  input  1  access request from requester 0 (CPU) / 1 (loader).
REQ-006 The block SHALL have ports we0/we1  input  1  1 = write, 0 = read; qualified by reqN.
REQ-007 The block SHALL have ports addr0/addr1  input  AW  access address.
REQ-008 The block SHALL have ports wdata0/wdata1  input  DW  write data.
REQ-009 The block SHALL have ports gnt0/gnt1  output  1  one-cycle grant pulse: request accepted.
REQ-010 The block SHALL have ports rvalid0/rvalid1  output  1  one-cycle read-data-valid pulse.
REQ-011 The block SHALL have port rdata  output  DW  read data, shared; valid while rvalid0 or rvalid1 is high.
REQ-012 The block SHALL have port busy  output  1  high in every state except IDLE.
REQ-013 The block SHALL have ports ram_raddr  output  AW, ram_waddr  output  AW, ram_wdata  output  DW, ram_we  output  1  RAM-side address/data/write strobe.
REQ-014 The block SHALL have port ram_rdata  input  DW  RAM read data, valid one cycle after the RAM samples ram_raddr.

Function
REQ-015 All outputs SHALL be registered.
REQ-016 The FSM SHALL have states IDLE, ACCESS, RWAIT, RDONE; one transaction in flight at a time.
REQ-017 In IDLE with any reqN high: select winner, latch its we/addr/wdata, go to ACCESS, pulse gntN for the ACCESS cycle only.
REQ-018 Arbitration SHALL be round-robin: if both request, grant the port not granted last; the last-granted pointer SHALL update on every grant.
REQ-019 With one requester active, it SHALL be granted regardless of the pointer; no port waits more than one foreign transaction.
REQ-020 Requests SHALL be sampled only in IDLE; a requester SHALL hold reqN and its operands until it sees gntN and SHALL deassert reqN the cycle after gntN unless it issues a new request.
REQ-021 Write: during ACCESS, ram_waddr/ram_wdata = latched values and ram_we = 1 for exactly one cycle; ACCESS -> IDLE. The next grant SHALL be possible 2 cycles after the previous one.
REQ-022 Read: during ACCESS, ram_raddr = latched address, ram_we = 0; ACCESS -> RWAIT -> RDONE; at the RWAIT->RDONE edge rdata <= ram_rdata.
REQ-023 In RDONE, rvalidN of the granted port SHALL be 1 for one cycle; RDONE -> IDLE. Grant-to-rvalid latency is 2 cycles; the next grant is possible 4 cycles after a read grant.
REQ-024 ram_raddr, ram_waddr, ram_wdata and rdata SHALL hold their last values when not updated.
REQ-025 ram_we, gnt0/1 and rvalid0/1 SHALL be 0 in every cycle not listed above; gnt0 and gnt1 SHALL never be high together, and likewise rvalid0/rvalid1.
REQ-026 An address at the maximum value (2^AW-1) SHALL be passed through unmodified; no address arithmetic.

Reset
REQ-027 On rst: state <= IDLE, pointer <= "last granted = 1" (port 0 wins the first tie), and gnt0/1, rvalid0/1, ram_we, busy <= 0.
REQ-028 On rst: ram_raddr, ram_waddr, ram_wdata, rdata <= 0.
REQ-029 rst asserted mid-transaction SHALL abort it: no ram_we, gnt or rvalid pulse in the cycle after rst, and no pending request survives.
REQ-030 rst SHALL have priority over all other inputs.

Verification
REQ-031 Single write: req0=1, we0=1, addr0=0x1A5, wdata0=0x3C -> gnt0 next cycle; ram_we=1, ram_waddr=0x1A5, ram_wdata=0x3C in that same cycle; busy 1 for one cycle.
REQ-032 Single read: RAM model holds 0x7E at 0x010; req1 read of 0x010 -> gnt1 at T, rvalid1=1 with rdata=0x7E at T+2, rvalid0 stays 0.
REQ-033 Contention: req0 and req1 both held after reset with writes -> grants in the order 0,1,0,1, spaced 2 cycles apart; no double grants.
REQ-034 Back-to-back: port 0 issues 4 consecutive reads of 0x000..0x003 while req1 is low -> 4 rvalid0 pulses 4 cycles apart with the matching data.
REQ-035 Reset abort: rst asserted during RWAIT of a read -> no rvalid, busy=0, all outputs at their reset values the next cycle; a request after rst is granted normally.
REQ-036 Boundary: write then read of address 0x1FF with data 0xFF -> ram_waddr/ram_raddr = 0x1FF, read returns 0xFF.
